alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
// - Execute pipeline stage wrapping the ALU: accepts one decoded op per cycle from decode, drives the ALU,
//   evaluates the ARM condition code against the architectural NZCV flags register it owns, and hands a
//   registered writeback (rd, data, we) to the writeback stage over a valid/ready handshake.
// - Also keeps retire / condition-fail counters for bring-up.
// PARAMETERS
// - DATA_W   32  operand/result width (ALU is fixed at 32; other values unsupported)
// - REG_AW   4   destination register index width (r0..r15)
// - CNT_W    32  width of the perf counters
// PORTS
// - clk           in   1       clock, all state on rising edge
// - rst_n         in   1       asynchronous active-low reset
// - in_valid      in   1       decode presents an op
// - in_ready      out  1       stage can accept this cycle
// - in_uop        in   5       ALU micro-op: 1 ADD,2 SUB,3 AND,4 XOR,5 CMP,6 LSL,7 LSR,8 MOV; others = NOP
// - in_lhs        in   DATA_W  first operand (Rn)
// - in_rhs        in   DATA_W  second operand (Rm/imm; MOV source)
// - in_rd         in   REG_AW  destination register
// - in_cond       in   4       ARM condition code (0 EQ .. 14 AL, 15 treated as AL)
// - in_setflags   in   1       S-bit: update flags from this op
// - flush         in   1       discard held and incoming ops (branch redirect)
// - out_valid     out  1       registered op ready for writeback
// - out_ready     in   1       writeback accepts
// - out_rd        out  REG_AW  destination register
// - out_data      out  DATA_W  ALU result
// - out_we        out  1       write rd (0 for CMP, NOP, cond-fail)
// - flags_q       out  4       architectural flags, order [Z,C,N,V]
// - retired_cnt   out  CNT_W   ops handed off (out_valid&&out_ready)
// - condfail_cnt  out  CNT_W   accepted ops whose condition failed
// BEHAVIOUR
// - Reset (async, any time): out_valid=0, out_we=0, out_rd=0, out_data=0, flags_q=4'b0000, both counters=0;
//   an op in flight is lost; in_ready=1 on the first cycle after release.
// - in_ready = !out_valid || out_ready (one-entry stage, full throughput, no combinational path out_ready->in_*
//   other than in_ready). Accept = in_valid && in_ready && !flush.
// - Latency 1: op accepted at edge N is on out_* from edge N, held stable while out_valid && !out_ready.
// - ALU is combinational on in_lhs/in_rhs/in_uop; result and flags captured only on accept.
// - Condition pass uses flags_q at accept: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z,
//   LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL/15 1.
// - out_we = pass && uop in {ADD,SUB,AND,XOR,LSL,LSR,MOV}. CMP never writes.
// - flags_q <= ALU flags on accept iff pass && (in_setflags || uop==CMP) && uop is a defined op. NOP and
//   cond-fail never touch flags. Back-to-back dependency is safe: next op sees updated flags_q.
// - Cond-fail and NOP ops still retire (out_valid=1, out_we=0) to keep in-order retire; out_data = ALU result.
// - condfail_cnt +1 per accepted cond-fail op; retired_cnt +1 per handoff; both wrap modulo 2^CNT_W.
// - flush: out_valid<=0 next edge (held op dropped even if out_ready=1 that cycle, not counted as retired);
//   incoming op not accepted; flags unchanged. flush outranks accept and handoff.
// - Handoff and accept in the same cycle: new op replaces old, out_valid stays 1.
// - out_valid=0: out_we forced 0; out_rd/out_data are don't-care but not X after reset.
// STRUCTURE
// - Package alu_pkg: uop codes (UOP_NOP..UOP_MOV), cond codes (COND_EQ..COND_AL), flag bit indices
//   (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0), shared with ALU and decode.
// - Instantiates existing ALU; one natural sub-module: cond_eval (cond[3:0], flags[3:0] -> pass), combinational.
// - Stage register, flags register and counters live in this module.
// TESTING
// - ADD 0+1, S=1, AL, rd=2, out_ready=1 -> next cycle out_valid=1, out_rd=2, out_data=1, out_we=1, flags_q Z=0.
// - CMP 5,5 -> out_we=0, flags_q Z=1; then MOV 0x12345678 EQ rd=3 -> out_we=1; then MOV NE -> out_we=0,
//   condfail_cnt=1, flags unchanged.
// - Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, one accept only;
//   release -> next op issued, retired_cnt increments by 1 per handoff.
// - flush with op held and new op presented -> out_valid=0 next cycle, flags_q and retired_cnt unchanged.
// - Assert rst_n=0 mid-stream asynchronously -> all outputs zero immediately; first op after release
//   accepted in 1 cycle; uop=0/uop=31 -> retire with out_we=0, flags unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: micro-op codes, ARM condition codes and NZCV flag bit positions.
// Used by the ALU, the condition evaluator, the execute stage and decode.
package alu_pkg;

   typedef enum logic [4:0] {
      UOP_NOP = 5'd0,
      UOP_ADD = 5'd1,
      UOP_SUB = 5'd2,
      UOP_AND = 5'd3,
      UOP_XOR = 5'd4,
      UOP_CMP = 5'd5,
      UOP_LSL = 5'd6,
      UOP_LSR = 5'd7,
      UOP_MOV = 5'd8
   } uop_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14
   } cond_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   function automatic logic uop_defined(input logic [4:0] uop);
      return (uop >= UOP_ADD) && (uop <= UOP_MOV);
   endfunction

   function automatic logic uop_writes(input logic [4:0] uop);
      return uop_defined(uop) && (uop != UOP_CMP);
   endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational 32-bit ALU producing a result and NZCV flags in [Z,C,N,V] order.
// Shifts use rhs[4:0]; C is the last bit shifted out (0 for a zero shift), logic ops clear C and V.
module alu
   import alu_pkg::*;
(
   input  logic [4:0]  uop,
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   logic signed [31:0] lhs_s;
   logic signed [31:0] rhs_s;
   logic signed [31:0] sum_s;
   logic signed [31:0] diff_s;
   logic [32:0]        sum_x;
   logic [32:0]        diff_x;
   logic [32:0]        shl_x;
   logic [32:0]        shr_x;
   logic [4:0]         shamt;
   logic               c;
   logic               v;

   assign lhs_s  = signed'(lhs);
   assign rhs_s  = signed'(rhs);
   assign sum_s  = lhs_s + rhs_s;
   assign diff_s = lhs_s - rhs_s;
   assign sum_x  = {1'b0, lhs} + {1'b0, rhs};
   assign diff_x = {1'b0, lhs} - {1'b0, rhs};
   assign shamt  = rhs[4:0];
   assign shl_x  = {1'b0, lhs} << shamt;
   assign shr_x  = {lhs, 1'b0} >> shamt;

   always_comb begin
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      case (uop)
         UOP_ADD: begin
            result = sum_x[31:0];
            c      = sum_x[32];
            v      = (lhs_s[31] == rhs_s[31]) && (sum_s[31] != lhs_s[31]);
         end
         UOP_SUB, UOP_CMP: begin
            // ARM carry on subtract means "no borrow"
            result = diff_x[31:0];
            c      = ~diff_x[32];
            v      = (lhs_s[31] != rhs_s[31]) && (diff_s[31] != lhs_s[31]);
         end
         UOP_AND: result = lhs & rhs;
         UOP_XOR: result = lhs ^ rhs;
         UOP_LSL: begin
            result = shl_x[31:0];
            c      = shl_x[32];
         end
         UOP_LSR: begin
            result = shr_x[32:1];
            c      = shr_x[0];
         end
         UOP_MOV: result = rhs;
         default: result = '0;
      endcase
   end

   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (result == 32'd0);
      flags[FLAG_C] = c;
      flags[FLAG_N] = result[31];
      flags[FLAG_V] = v;
   end

endmodule

// File: rtl/alu_exec_stage_cond_eval.sv
// ARM condition-code evaluator against [Z,C,N,V] flags; code 15 behaves as AL.
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic z, c, n, v;

   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];

   always_comb begin
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one-entry registered slot between decode and writeback, owning the NZCV flags
// register and bring-up retire / condition-fail counters.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_uop,
   input  logic [DATA_W-1:0] in_lhs,
   input  logic [DATA_W-1:0] in_rhs,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [3:0]        in_cond,
   input  logic              in_setflags,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_we,
   output logic [3:0]        flags_q,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  condfail_cnt
);

   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flags;
   logic              pass;
   logic              accept;
   logic              handoff;
   logic              flag_upd;

   logic              vld_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [DATA_W-1:0] data_p1;
   logic              we_p1;
   logic [3:0]        flags_r;
   logic [CNT_W-1:0]  ret_r;
   logic [CNT_W-1:0]  cf_r;

   alu u_alu (
      .uop    (in_uop),
      .lhs    (in_lhs),
      .rhs    (in_rhs),
      .result (alu_res),
      .flags  (alu_flags)
   );

   cond_eval u_cond (
      .cond  (in_cond),
      .flags (flags_r),
      .pass  (pass)
   );

   assign in_ready = ~vld_p1 | out_ready;
   assign accept   = in_valid & in_ready & ~flush;
   assign handoff  = vld_p1 & out_ready & ~flush;
   assign flag_upd = accept & pass & uop_defined(in_uop) & (in_setflags | (in_uop == UOP_CMP));

   // ---- stage p0 -> p1: capture accepted op; flush outranks accept and handoff
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         rd_p1   <= '0;
         data_p1 <= '0;
         we_p1   <= 1'b0;
      end else if (flush) begin
         vld_p1  <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         rd_p1   <= in_rd;
         data_p1 <= alu_res;
         we_p1   <= pass & uop_writes(in_uop);
      end else if (handoff) begin
         vld_p1  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= 4'b0000;
         ret_r   <= '0;
         cf_r    <= '0;
      end else begin
         if (flag_upd)
            flags_r <= alu_flags;
         if (handoff)
            ret_r <= ret_r + 1'b1;
         if (accept && !pass)
            cf_r <= cf_r + 1'b1;
      end
   end

   assign out_valid    = vld_p1;
   assign out_rd       = rd_p1;
   assign out_data     = data_p1;
   assign out_we       = vld_p1 & we_p1;
   assign flags_q      = flags_r;
   assign retired_cnt  = ret_r;
   assign condfail_cnt = cf_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage against an arithmetic reference model of the execute stage,
// with directed, hand-computed checks for reset, flags, condition codes, backpressure and flush.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_setflags, flush;
   logic [4:0]  in_uop;
   logic [31:0] in_lhs, in_rhs;
   logic [3:0]  in_rd, in_cond;
   logic        out_valid, out_ready, out_we;
   logic [3:0]  out_rd, flags_q;
   logic [31:0] out_data, retired_cnt, condfail_cnt;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   alu_exec_stage #(.DATA_W(32), .REG_AW(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
      .in_lhs(in_lhs), .in_rhs(in_rhs), .in_rd(in_rd), .in_cond(in_cond),
      .in_setflags(in_setflags), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_data(out_data), .out_we(out_we), .flags_q(flags_q),
      .retired_cnt(retired_cnt), .condfail_cnt(condfail_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_result(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = 32'd0;
      case (u)
         5'd1: r = a + b;
         5'd2, 5'd5: r = a - b;
         5'd3: r = a & b;
         5'd4: r = a ^ b;
         5'd6: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0}; end
         5'd7: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]}; end
         5'd8: r = b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] m_flags(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r, t;
      logic c, v;
      longint s;
      longint unsigned us;
      r = m_result(u, a, b);
      c = 1'b0;
      v = 1'b0;
      case (u)
         5'd1: begin
            us = longint'(a) + longint'(b);
            c  = us > 64'hFFFF_FFFF;
            s  = longint'($signed(a)) + longint'($signed(b));
            v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'd2, 5'd5: begin
            c = a >= b;
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'd6: begin t = a; for (int i = 0; i < int'(b[4:0]); i++) begin c = t[31]; t = t << 1; end end
         5'd7: begin t = a; for (int i = 0; i < int'(b[4:0]); i++) begin c = t[0]; t = t >> 1; end end
         default: ;
      endcase
      return {r == 32'd0, c, r[31], v};
   endfunction

   function automatic logic m_pass(input logic [3:0] cnd, input logic [3:0] f);
      logic z, c, n, v;
      {z, c, n, v} = f;
      case (cnd)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   logic        m_vld, m_we;
   logic [3:0]  m_rd, m_fl;
   logic [31:0] m_data, m_ret, m_cf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld <= 1'b0; m_we <= 1'b0; m_rd <= '0; m_data <= '0;
         m_fl <= 4'b0000; m_ret <= '0; m_cf <= '0;
      end else begin
         if (!flush && m_vld && out_ready)
            m_ret <= m_ret + 1;
         if (flush) begin
            m_vld <= 1'b0;
         end else if (in_valid && (!m_vld || out_ready)) begin
            m_vld  <= 1'b1;
            m_rd   <= in_rd;
            m_data <= m_result(in_uop, in_lhs, in_rhs);
            m_we   <= m_pass(in_cond, m_fl) && (in_uop inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8});
            if (m_pass(in_cond, m_fl) && (in_uop inside {[5'd1:5'd8]}) && (in_setflags || in_uop == 5'd5))
               m_fl <= m_flags(in_uop, in_lhs, in_rhs);
            if (!m_pass(in_cond, m_fl))
               m_cf <= m_cf + 1;
         end else if (m_vld && out_ready) begin
            m_vld <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
         chk("out_we", {31'd0, out_we}, {31'd0, m_vld && m_we});
         if (m_vld) begin
            chk("out_rd", {28'd0, out_rd}, {28'd0, m_rd});
            chk("out_data", out_data, m_data);
         end
         chk("flags_q", {28'd0, flags_q}, {28'd0, m_fl});
         chk("retired_cnt", retired_cnt, m_ret);
         chk("condfail_cnt", condfail_cnt, m_cf);
         chk("in_ready", {31'd0, in_ready}, {31'd0, !m_vld || out_ready});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rd, input logic [3:0] cnd, input logic s);
      in_valid = 1'b1; in_uop = u; in_lhs = a; in_rhs = b;
      in_rd = rd; in_cond = cnd; in_setflags = s;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 3))
         0: return $urandom_range(0, 8);
         1: case ($urandom_range(0, 3))
               0: return 32'h7FFF_FFFF;
               1: return 32'h8000_0000;
               2: return 32'hFFFF_FFFF;
               default: return 32'd0;
            endcase
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_uop = '0; in_lhs = '0; in_rhs = '0;
      in_rd = '0; in_cond = 4'd14; in_setflags = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst flags", {28'd0, flags_q}, 32'd0);
      chk("rst retired", retired_cnt, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("in_ready after release", {31'd0, in_ready}, 32'd1);
      cmp_en = 1'b1;
      step();

      drive(5'd1, 32'd0, 32'd1, 4'd2, 4'd14, 1'b1);
      step();
      chk("add valid", {31'd0, out_valid}, 32'd1);
      chk("add rd", {28'd0, out_rd}, 32'd2);
      chk("add data", out_data, 32'd1);
      chk("add we", {31'd0, out_we}, 32'd1);
      chk("add flags", {28'd0, flags_q}, 32'h0);

      drive(5'd5, 32'd5, 32'd5, 4'd0, 4'd14, 1'b0);
      step();
      chk("cmp we", {31'd0, out_we}, 32'd0);
      chk("cmp flags", {28'd0, flags_q}, 32'hC);

      drive(5'd8, 32'd0, 32'h1234_5678, 4'd3, 4'd0, 1'b0);
      step();
      chk("mov eq we", {31'd0, out_we}, 32'd1);
      chk("mov eq data", out_data, 32'h1234_5678);

      drive(5'd8, 32'd0, 32'h1234_5678, 4'd3, 4'd1, 1'b0);
      step();
      chk("mov ne we", {31'd0, out_we}, 32'd0);
      chk("mov ne condfail", condfail_cnt, 32'd1);
      chk("mov ne flags", {28'd0, flags_q}, 32'hC);
      chk("retired 3", retired_cnt, 32'd3);

      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      drive(5'd1, 32'd3, 32'd4, 4'd5, 4'd14, 1'b0);
      step();
      drive(5'd1, 32'd10, 32'd10, 4'd6, 4'd14, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp rd", {28'd0, out_rd}, 32'd5);
         chk("bp data", out_data, 32'd7);
         chk("bp retired", retired_cnt, 32'd4);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("bp next data", out_data, 32'd20);
      chk("bp next retired", retired_cnt, 32'd5);
      in_valid = 1'b0;
      step();

      out_ready = 1'b0;
      drive(5'd2, 32'd9, 32'd4, 4'd7, 4'd14, 1'b1);
      step();
      chk("sub flags", {28'd0, flags_q}, 32'h4);
      drive(5'd1, 32'd0, 32'd0, 4'd8, 4'd14, 1'b1);
      out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush valid", {31'd0, out_valid}, 32'd0);
      chk("flush flags", {28'd0, flags_q}, 32'h4);
      chk("flush retired", retired_cnt, 32'd6);

      out_ready = 1'b0;
      drive(5'd8, 32'd0, 32'hDEAD_BEEF, 4'd9, 4'd14, 1'b0);
      step();
      cmp_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst valid", {31'd0, out_valid}, 32'd0);
      chk("arst we", {31'd0, out_we}, 32'd0);
      chk("arst rd", {28'd0, out_rd}, 32'd0);
      chk("arst data", out_data, 32'd0);
      chk("arst flags", {28'd0, flags_q}, 32'd0);
      chk("arst counters", retired_cnt | condfail_cnt, 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      cmp_en = 1'b1;
      drive(5'd0, 32'd1, 32'd2, 4'd9, 4'd14, 1'b1);
      step();
      chk("nop valid", {31'd0, out_valid}, 32'd1);
      chk("nop we", {31'd0, out_we}, 32'd0);
      chk("nop flags", {28'd0, flags_q}, 32'd0);
      drive(5'd31, 32'h8000_0000, 32'h8000_0000, 4'd10, 4'd15, 1'b1);
      step();
      chk("uop31 we", {31'd0, out_we}, 32'd0);
      chk("uop31 flags", {28'd0, flags_q}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         in_valid    = ($urandom_range(0, 9) < 8);
         out_ready   = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 19) == 0);
         in_uop      = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
         in_lhs      = rnd_operand();
         in_rhs      = rnd_operand();
         in_rd       = 4'($urandom_range(0, 15));
         in_cond     = 4'($urandom_range(0, 15));
         in_setflags = $urandom_range(0, 1) == 1;
         step();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
